// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the LTC1407A-style dual-channel ADC reader.
// The frame layout is fixed by the ADC: two 14-bit samples inside a 34-bit SPI frame.
package adc_pkg;

   localparam int FRAME_BITS  = 34;
   localparam int SAMPLE_W    = 14;
   localparam int A_FIRST_BIT = 2;
   localparam int B_FIRST_BIT = 18;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CONV  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;

   // True when frame bit idx belongs to the sample field starting at first.
   function automatic logic in_field(input logic [5:0] idx, input int first);
      return (int'(idx) >= first) && (int'(idx) < first + SAMPLE_W);
   endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SPI clock generator: DIV-cycle half periods, low half first, held low while disabled.
// rise/fall mark the clock edge that will toggle SCK; count is the current SCK period index.
module adc_sck_gen #(
   parameter int DIV = 2
) (
   input  logic       CLK50MHZ,
   input  logic       RST,
   input  logic       en,
   output logic       sck,
   output logic       rise,
   output logic       fall,
   output logic [5:0] count
);

   localparam logic [15:0] HALF_RELOAD = 16'(DIV - 1);

   logic [15:0] half_q, half_d;
   logic        sck_q, sck_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        tc;

   always_comb begin
      tc     = (half_q == '0);
      rise   = en && tc && !sck_q;
      fall   = en && tc && sck_q;
      half_d = half_q;
      sck_d  = sck_q;
      cnt_d  = cnt_q;
      if (!en) begin
         half_d = HALF_RELOAD;
         sck_d  = 1'b0;
         cnt_d  = '0;
      end else if (tc) begin
         half_d = HALF_RELOAD;
         sck_d  = !sck_q;
         // a period ends on its falling edge
         if (sck_q) cnt_d = cnt_q + 6'd1;
      end else begin
         half_d = half_q - 16'd1;
      end
   end

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         half_q <= '0;
         sck_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         half_q <= half_d;
         sck_q  <= sck_d;
         cnt_q  <= cnt_d;
      end
   end

   assign sck   = sck_q;
   assign count = cnt_q;

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master for the dual-channel 14-bit ADC: convert strobe, one 34-bit frame, done pulse.
//   state    | meaning
//   IDLE     | waiting for trig, all strobes low
//   CONV     | ad_conv high for CONV_CYCLES clocks
//   SHIFT    | 34 SCK periods, samples shifted into shadow registers
//   DONE     | shadows copied to outputs, done pulse
module adc_spi_reader
   import adc_pkg::*;
#(
   parameter int DIV         = 2,
   parameter int CONV_CYCLES = 2
) (
   input  logic        CLK50MHZ,
   input  logic        RST,
   input  logic        trig,
   output logic        done,
   output logic        busy,
   output logic [13:0] adc_a,
   output logic [13:0] adc_b,
   output logic        ad_conv,
   output logic        spi_sck,
   input  logic        spi_miso
);

   localparam logic [15:0] CONV_RELOAD = 16'(CONV_CYCLES - 1);
   localparam logic [5:0]  LAST_BIT    = 6'(FRAME_BITS - 1);

   logic [2:0]  state_q, state_d;
   logic [15:0] conv_q, conv_d;
   logic        ad_conv_q, ad_conv_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic [13:0] adc_a_q, adc_a_d;
   logic [13:0] adc_b_q, adc_b_d;
   logic [13:0] sha_q, sha_d;
   logic [13:0] shb_q, shb_d;

   logic       sck_en;
   logic       sck_rise;
   logic       sck_fall;
   logic [5:0] bit_idx;

   assign sck_en = (state_q == ST_SHIFT);

   adc_sck_gen #(.DIV(DIV)) u_sck (
      .CLK50MHZ (CLK50MHZ),
      .RST      (RST),
      .en       (sck_en),
      .sck      (spi_sck),
      .rise     (sck_rise),
      .fall     (sck_fall),
      .count    (bit_idx)
   );

   always_comb begin
      state_d   = state_q;
      conv_d    = conv_q;
      ad_conv_d = 1'b0;
      done_d    = 1'b0;
      busy_d    = busy_q;
      adc_a_d   = adc_a_q;
      adc_b_d   = adc_b_q;
      sha_d     = sha_q;
      shb_d     = shb_q;
      case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d   = ST_CONV;
               conv_d    = CONV_RELOAD;
               ad_conv_d = 1'b1;
               busy_d    = 1'b1;
            end
         end
         ST_CONV: begin
            if (conv_q == '0) begin
               state_d = ST_SHIFT;
            end else begin
               conv_d    = conv_q - 16'd1;
               ad_conv_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            // sample on the edge that raises SCK: end of the low half, data settled
            if (sck_rise) begin
               if (in_field(bit_idx, A_FIRST_BIT)) sha_d = {sha_q[12:0], spi_miso};
               if (in_field(bit_idx, B_FIRST_BIT)) shb_d = {shb_q[12:0], spi_miso};
            end
            if (sck_fall && (bit_idx == LAST_BIT)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               adc_a_d = sha_q;
               adc_b_d = shb_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         conv_q    <= '0;
         ad_conv_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         adc_a_q   <= '0;
         adc_b_q   <= '0;
         sha_q     <= '0;
         shb_q     <= '0;
      end else begin
         state_q   <= state_d;
         conv_q    <= conv_d;
         ad_conv_q <= ad_conv_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         adc_a_q   <= adc_a_d;
         adc_b_q   <= adc_b_d;
         sha_q     <= sha_d;
         shb_q     <= shb_d;
      end
   end

   assign ad_conv = ad_conv_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign adc_a   = adc_a_q;
   assign adc_b   = adc_b_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: default instance plus a DIV=1/CONV_CYCLES=1 instance,
// each fed by a behavioural ADC that shifts frames out on SCK falling edges.
module tb_adc_spi_reader;

   logic CLK50MHZ = 1'b0;
   logic RST      = 1'b1;
   logic trig0    = 1'b0;
   logic trig1    = 1'b0;

   logic        done0, busy0, ad_conv0, spi_sck0;
   logic        done1, busy1, ad_conv1, spi_sck1;
   logic [13:0] adc_a0, adc_b0, adc_a1, adc_b1;
   logic        miso0 = 1'b1;
   logic        miso1 = 1'b1;

   always #10 CLK50MHZ = ~CLK50MHZ;

   adc_spi_reader dut0 (
      .CLK50MHZ (CLK50MHZ),
      .RST      (RST),
      .trig     (trig0),
      .done     (done0),
      .busy     (busy0),
      .adc_a    (adc_a0),
      .adc_b    (adc_b0),
      .ad_conv  (ad_conv0),
      .spi_sck  (spi_sck0),
      .spi_miso (miso0)
   );

   adc_spi_reader #(.DIV(1), .CONV_CYCLES(1)) dut1 (
      .CLK50MHZ (CLK50MHZ),
      .RST      (RST),
      .trig     (trig1),
      .done     (done1),
      .busy     (busy1),
      .adc_a    (adc_a1),
      .adc_b    (adc_b1),
      .ad_conv  (ad_conv1),
      .spi_sck  (spi_sck1),
      .spi_miso (miso1)
   );

   // sample sequence served by the ADC models, one entry per conversion
   logic [13:0] seq_a [8] = '{14'h2155, 14'h2000, 14'h3FFF, 14'h0001,
                              14'h1234, 14'h3ABC, 14'h0F00, 14'h1555};
   logic [13:0] seq_b [8] = '{14'h0AAA, 14'h1FFF, 14'h3FFF, 14'h2000,
                              14'h0F0F, 14'h0123, 14'h3FFE, 14'h2AAA};

   // hi-Z positions are driven 1 so any leak into the samples shows up
   logic [33:0] fr0 = '1;
   logic [33:0] fr1 = '1;
   int bi0 = 0, bi1 = 0;
   int conv_n0 = 0, conv_n1 = 0;

   always @(posedge ad_conv0 or negedge spi_sck0) begin
      if (ad_conv0) begin
         fr0 = {2'b11, seq_a[conv_n0 % 8], 2'b11, seq_b[conv_n0 % 8], 2'b11};
         conv_n0++;
         bi0 = 0;
      end else if (bi0 < 33) begin
         bi0++;
      end
      miso0 = fr0[33 - bi0];
   end

   always @(posedge ad_conv1 or negedge spi_sck1) begin
      if (ad_conv1) begin
         fr1 = {2'b11, seq_a[conv_n1 % 8], 2'b11, seq_b[conv_n1 % 8], 2'b11};
         conv_n1++;
         bi1 = 0;
      end else if (bi1 < 33) begin
         bi1++;
      end
      miso1 = fr1[33 - bi1];
   end

   // free-running activity counters; tests work on differences
   int   cyc = 0;
   int   ac_n   [2] = '{0, 0};
   int   rise_n [2] = '{0, 0};
   int   done_n [2] = '{0, 0};
   int   ovl_n  [2] = '{0, 0};
   logic sp0 = 1'b0, sp1 = 1'b0;

   always @(posedge CLK50MHZ) begin
      cyc++;
      if (ad_conv0) ac_n[0]++;
      if (ad_conv1) ac_n[1]++;
      if (spi_sck0 && !sp0) rise_n[0]++;
      if (spi_sck1 && !sp1) rise_n[1]++;
      if (done0) done_n[0]++;
      if (done1) done_n[1]++;
      if (ad_conv0 && spi_sck0) ovl_n[0]++;
      if (ad_conv1 && spi_sck1) ovl_n[1]++;
      sp0 = spi_sck0;
      sp1 = spi_sck1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge CLK50MHZ);
      #1;
   endtask

   // one triggered frame on instance u, checked for timing, strobes and data
   task automatic frame(input bit u, input int exp_lat, input int exp_conv, input string tag);
      int lat, ac, rs, dn, ov, idx;
      logic [13:0] ea, eb;
      idx = u ? conv_n1 : conv_n0;
      ea  = seq_a[idx % 8];
      eb  = seq_b[idx % 8];
      @(negedge CLK50MHZ);
      if (u) trig1 = 1'b1; else trig0 = 1'b1;
      ac = ac_n[u]; rs = rise_n[u]; dn = done_n[u]; ov = ovl_n[u];
      @(posedge CLK50MHZ); #1;
      trig0 = 1'b0; trig1 = 1'b0;
      chk({tag, "_busy_start"}, 32'(u ? busy1 : busy0), 32'd1);
      lat = 1;
      while (!(u ? done1 : done0) && lat < 400) begin
         @(posedge CLK50MHZ); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_adc_a"}, 32'(u ? adc_a1 : adc_a0), 32'(ea));
      chk({tag, "_adc_b"}, 32'(u ? adc_b1 : adc_b0), 32'(eb));
      chk({tag, "_conv_cycles"}, ac_n[u] - ac, exp_conv);
      chk({tag, "_sck_pulses"}, rise_n[u] - rs, 34);
      chk({tag, "_conv_sck_overlap"}, ovl_n[u] - ov, 0);
      @(posedge CLK50MHZ); #1;
      chk({tag, "_done_one_cycle"}, 32'(u ? done1 : done0), 32'd0);
      chk({tag, "_busy_end"}, 32'(u ? busy1 : busy0), 32'd0);
      chk({tag, "_done_count"}, done_n[u] - dn, 1);
   endtask

   initial begin
      int base, nd, prev, r0, d0, n;

      // reset
      cycles(3);
      chk("rst_done", 32'(done0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_adc_a", 32'(adc_a0), 0);
      chk("rst_adc_b", 32'(adc_b0), 0);
      chk("rst_ad_conv", 32'(ad_conv0), 0);
      chk("rst_sck", 32'(spi_sck0), 0);
      chk("rst_dut1_busy", 32'(busy1), 0);
      @(negedge CLK50MHZ) RST = 1'b0;
      r0 = rise_n[0]; n = ac_n[0];
      cycles(200);
      chk("idle_no_sck", rise_n[0] - r0, 0);
      chk("idle_no_conv", ac_n[0] - n, 0);
      chk("idle_busy", 32'(busy0), 0);

      // nominal frame, then extremes
      frame(1'b0, 139, 2, "nominal");
      frame(1'b0, 139, 2, "ext_2000_1fff");
      frame(1'b0, 139, 2, "ext_3fff");

      // trig pulses during SHIFT are ignored
      base = conv_n0;
      d0 = done_n[0];
      @(negedge CLK50MHZ) trig0 = 1'b1;
      @(negedge CLK50MHZ) trig0 = 1'b0;
      for (int p = 0; p < 5; p++) begin
         repeat (15) @(negedge CLK50MHZ);
         trig0 = 1'b1;
         @(negedge CLK50MHZ) trig0 = 1'b0;
      end
      cycles(250);
      chk("hs_single_done", done_n[0] - d0, 1);
      chk("hs_adc_a", 32'(adc_a0), 32'(seq_a[base % 8]));
      chk("hs_adc_b", 32'(adc_b0), 32'(seq_b[base % 8]));
      chk("hs_conversions", conv_n0 - base, 1);

      // trig held high for 1000 cycles
      base = conv_n0;
      nd = 0;
      prev = 0;
      @(negedge CLK50MHZ) trig0 = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         @(posedge CLK50MHZ); #1;
         if (done0) begin
            chk("held_adc_a", 32'(adc_a0), 32'(seq_a[(base + nd) % 8]));
            chk("held_adc_b", 32'(adc_b0), 32'(seq_b[(base + nd) % 8]));
            if (nd > 0) chk("held_period", cyc - prev, 140);
            prev = cyc;
            nd++;
         end
      end
      trig0 = 1'b0;
      chk("held_done_count", nd, 7);
      cycles(200);

      // reset in the middle of a frame
      d0 = done_n[0];
      @(negedge CLK50MHZ) trig0 = 1'b1;
      r0 = rise_n[0];
      @(negedge CLK50MHZ) trig0 = 1'b0;
      n = 0;
      while ((rise_n[0] - r0) < 10 && n < 400) begin
         @(posedge CLK50MHZ); #1;
         n++;
      end
      chk("abort_reached_pulse10", 32'(n < 400), 32'd1);
      @(negedge CLK50MHZ) RST = 1'b1;
      @(posedge CLK50MHZ); #1;
      chk("abort_sck", 32'(spi_sck0), 0);
      chk("abort_ad_conv", 32'(ad_conv0), 0);
      chk("abort_busy", 32'(busy0), 0);
      chk("abort_adc_a", 32'(adc_a0), 0);
      chk("abort_adc_b", 32'(adc_b0), 0);
      @(negedge CLK50MHZ) RST = 1'b0;
      cycles(300);
      chk("abort_no_done", done_n[0] - d0, 0);
      frame(1'b0, 139, 2, "after_abort");

      // fast instance
      frame(1'b1, 70, 1, "div1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_spi_reader.md
# adc_spi_reader

SPI master for the starter-kit dual-channel 14-bit ADC (LTC1407A-type) that serves the conversion-controller's `adc_trig`/`adc_done` handshake. On a trigger it pulses the ADC convert strobe, clocks one 34-bit SPI frame, extracts both channel samples, and presents them together with a one-cycle done pulse. It sits between the conversion controller and the board SPI pins, on the opposite side of the trigger/done handshake from the controller.

## Interface
- `DIV`, default 2: SCK half-period in CLK50MHZ cycles (SCK = 50 MHz / (2·DIV)); legal ≥ 1.
- `CONV_CYCLES`, default 2: width of the `ad_conv` pulse in clocks; legal ≥ 1.
- `CLK50MHZ`  in  1  system clock.
- `RST`  in  1  reset, synchronous, active-high; clock CLK50MHZ.
- `trig`  in  1  start-conversion request, sampled only in IDLE.
- `done`  out  1  one-cycle pulse; samples valid.
- `busy`  out  1  high from the cycle after trig is accepted through the done cycle.
- `adc_a`  out  14  channel A sample, two's complement, held until next done.
- `adc_b`  out  14  channel B sample, same format.
- `ad_conv`  out  1  ADC convert strobe.
- `spi_sck`  out  1  SPI clock, idle low.
- `spi_miso`  in  1  ADC serial data, MSB first.

## Operation
- States: IDLE → CONV → SHIFT → DONE → IDLE.
- IDLE: all strobes low; `trig`=1 moves to CONV.
- CONV: `ad_conv`=1 for exactly CONV_CYCLES clocks, `spi_sck`=0; then SHIFT.
- SHIFT: 34 SCK periods, each DIV clocks low then DIV clocks high. `spi_miso` is sampled on the clock edge that drives SCK high. Bit index 0..33: bits 2–15 → adc_a[13:0] (MSB first), bits 18–31 → adc_b[13:0]; bits 0,1,16,17,32,33 are discarded (hi-Z). Shifting goes into internal shadow registers, not the outputs.
- DONE: shadow values copied to `adc_a`/`adc_b` in the same cycle `done`=1; next cycle IDLE.
- `trig` in any state other than IDLE is ignored; it is not queued.
- `trig` held high continuously gives back-to-back conversions.
- RST in any state: next cycle IDLE, `ad_conv`=0, `spi_sck`=0, `done`=0, `busy`=0, `adc_a`=`adc_b`=0, shadows and counters cleared. An aborted frame never produces `done`.

## Timing
- All outputs are registered.
- Reset values: every output 0.
- `trig` sampled high at edge k (IDLE):
  - `ad_conv` high for cycles k+1 .. k+CONV_CYCLES.
  - SCK's first low half starts at cycle k+CONV_CYCLES+1.
  - `done` high during cycle k+CONV_CYCLES+68·DIV+1. Defaults give 139 clocks.
- Repetition period with `trig` held high: CONV_CYCLES+68·DIV+2 clocks. Defaults give 140.
- `spi_miso` is set up by the ADC on SCK falling edges; one half-period of setup is guaranteed because sampling happens at the end of the low half.
- `ad_conv` and `spi_sck` are never high simultaneously.

## Structure
- Shared package `adc_pkg`:
  - constants FRAME_BITS=34, SAMPLE_W=14, A_FIRST_BIT=2, B_FIRST_BIT=18.
  - state encoding (3-bit localparams, same style as the controller).
- Sub-module `adc_sck_gen`: half-period counter plus SCK toggle with enable. It outputs `rise` and `fall` strobes and a 6-bit period count. The FSM consumes the `rise` strobes for sampling and the count for bit indexing.

## Test plan
- Reset: assert RST 3 cycles, release → all outputs 0, `busy`=0; no SCK activity for 200 cycles without `trig`.
- Nominal frame: ADC model returns A=14'h2155, B=14'h0AAA, with hi-Z bits driven X/1.
  - `ad_conv` high exactly 2 cycles, then 34 SCK pulses.
  - `done` exactly 139 cycles after trig.
  - `adc_a`=14'h2155, `adc_b`=14'h0AAA.
- Extremes: A=14'h2000, B=14'h1FFF, then A=B=14'h3FFF → values reported exactly; hi-Z bit values never leak into outputs.
- Handshake: `trig` pulsed repeatedly during SHIFT → only one `done`. `trig` held high for 1000 cycles → a `done` every 140 cycles, 7 conversions, data matching the model sequence.
- Reset mid-operation: RST asserted at SCK pulse 10 → next cycle `spi_sck`=0 and `ad_conv`=0; no `done`; outputs 0. A following `trig` completes a normal frame.
- Parameterisation: DIV=1, CONV_CYCLES=1 → SCK 25 MHz, `done` at 70 cycles after trig, correct data.
